// File: rtl/rr_switch_arbiter.sv
// N-port round-robin arbiter with registered grant and owner data mux.
// Optional forced release after TIMEOUT_CYC grant cycles: define ARB_TIMEOUT_EN.
module rr_switch_arbiter #(
  parameter int unsigned NUM_PORTS   = 5,
  parameter int unsigned DATA_W      = 1,
  parameter int unsigned TIMEOUT_CYC = 256,
  localparam int unsigned ID_W       = $clog2(NUM_PORTS)
) (
  input  logic                        core_clock,
  input  logic                        core_rst_n,
  input  logic [NUM_PORTS-1:0]        req,
  input  logic [NUM_PORTS*DATA_W-1:0] din,
  output logic [NUM_PORTS-1:0]        gnt,
  output logic [ID_W-1:0]             owner_id,
  output logic                        busy,
  output logic [DATA_W-1:0]           dout,
  output logic                        dout_vld,
  output logic                        timeout
);

  if (NUM_PORTS < 2 || NUM_PORTS > 16) begin : g_bad_ports
    $error("rr_switch_arbiter: NUM_PORTS out of range 2..16");
  end
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_bad_timeout
    $error("rr_switch_arbiter: TIMEOUT_CYC out of range 2..65535");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_GUARD
  } state_e;

  state_e                state_q, state_d;
  logic [NUM_PORTS-1:0]  gnt_q, gnt_d;
  logic [ID_W-1:0]       owner_q, owner_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic [DATA_W-1:0]     dout_q, dout_d;
  logic                  vld_q, vld_d;

  logic [ID_W-1:0]       sel;
  logic                  sel_vld;
  logic [ID_W:0]         scan_sum;
  logic [ID_W-1:0]       owner_nxt;
  logic                  req_own;
  logic [DATA_W-1:0]     din_own;
  logic [DATA_W-1:0]     din_a [NUM_PORTS];

`ifdef ARB_TIMEOUT_EN
  logic [15:0]           cnt_q, cnt_d;
  logic                  to_q, to_d;
`endif

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
    assign din_a[g] = din[g*DATA_W +: DATA_W];
  end

  assign req_own   = req[owner_q];
  assign din_own   = din_a[owner_q];
  assign owner_nxt = (owner_q == ID_W'(NUM_PORTS - 1)) ? '0 : owner_q + 1'b1;

  // First set request scanning upward from ptr, wrapping at NUM_PORTS.
  always_comb begin
    sel      = '0;
    sel_vld  = 1'b0;
    scan_sum = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      scan_sum = {1'b0, ptr_q} + (ID_W+1)'(i);
      if (scan_sum >= (ID_W+1)'(NUM_PORTS)) begin
        scan_sum = scan_sum - (ID_W+1)'(NUM_PORTS);
      end
      if (!sel_vld && req[scan_sum[ID_W-1:0]]) begin
        sel     = scan_sum[ID_W-1:0];
        sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
`ifdef ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    to_d    = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (sel_vld) begin
          gnt_d      = '0;
          gnt_d[sel] = 1'b1;
          owner_d    = sel;
          state_d    = S_GRANT;
`ifdef ARB_TIMEOUT_EN
          cnt_d      = 16'd1;
`endif
        end
      end
      S_GRANT: begin
        if (!req_own) begin
          gnt_d   = '0;
          ptr_d   = owner_nxt;
          state_d = S_GUARD;
        end
`ifdef ARB_TIMEOUT_EN
        else if (cnt_q == 16'(TIMEOUT_CYC)) begin
          gnt_d   = '0;
          ptr_d   = owner_nxt;
          state_d = S_GUARD;
          to_d    = 1'b1;
        end else begin
          cnt_d   = cnt_q + 16'd1;
        end
`endif
      end
      S_GUARD: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign vld_d  = (state_q == S_GRANT) && req_own;
  assign dout_d = vld_d ? din_own : '0;

  always_ff @(posedge core_clock or negedge core_rst_n) begin
    if (!core_rst_n) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      dout_q  <= '0;
      vld_q   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= '0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      dout_q  <= dout_d;
      vld_q   <= vld_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      to_q    <= to_d;
`endif
    end
  end

  assign gnt      = gnt_q;
  assign owner_id = owner_q;
  assign busy     = |gnt_q;
  assign dout     = dout_q;
  assign dout_vld = vld_q;
`ifdef ARB_TIMEOUT_EN
  assign timeout  = to_q;
`else
  assign timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_rr_switch_arbiter.sv
// Bench for rr_switch_arbiter, 5 ports, bit-serial data.
// Build with ARB_TIMEOUT_EN to exercise forced release (TIMEOUT_CYC=8).
module tb_rr_switch_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned TO_CYC = 8;
`else
  localparam int unsigned TO_CYC = 256;
`endif

  logic       core_clock = 1'b0;
  logic       core_rst_n;
  logic [4:0] req;
  logic [4:0] din;
  logic [4:0] gnt;
  logic [2:0] owner_id;
  logic       busy;
  logic [0:0] dout;
  logic       dout_vld;
  logic       timeout;

  rr_switch_arbiter #(
    .NUM_PORTS  (5),
    .DATA_W     (1),
    .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .core_clock(core_clock),
    .core_rst_n(core_rst_n),
    .req       (req),
    .din       (din),
    .gnt       (gnt),
    .owner_id  (owner_id),
    .busy      (busy),
    .dout      (dout),
    .dout_vld  (dout_vld),
    .timeout   (timeout)
  );

  always #5 core_clock = ~core_clock;

  typedef struct {
    string      tag;
    logic [4:0] req;
    logic [4:0] din;
    logic [4:0] gnt;
    logic       busy;
    logic [2:0] owner;
    logic       vld;
    logic       dout;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string tag, input logic [4:0] r, input logic [4:0] d,
                     input logic [4:0] g, input logic b, input logic [2:0] o,
                     input logic v, input logic dt);
    vec_t e;
    e.tag = tag; e.req = r; e.din = d; e.gnt = g;
    e.busy = b; e.owner = o; e.vld = v; e.dout = dt;
    tbl.push_back(e);
  endtask

  task automatic check_vec(input int idx, input vec_t e);
    string n;
    n = $sformatf("%s#%0d", e.tag, idx);
    chk({n, ".gnt"},      32'(gnt),      32'(e.gnt));
    chk({n, ".busy"},     32'(busy),     32'(e.busy));
    chk({n, ".owner_id"}, 32'(owner_id), 32'(e.owner));
    chk({n, ".dout_vld"}, 32'(dout_vld), 32'(e.vld));
    chk({n, ".dout"},     32'(dout),     32'(e.dout));
    chk({n, ".timeout"},  32'(timeout),  32'(1'b0));
  endtask

  task automatic tick();
    @(posedge core_clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t e;
    logic [4:0] b;
    int unsigned rr_order [6];
    rr_order = '{0, 1, 2, 3, 4, 0};

    // Round robin with all ports requesting, each dropping for one cycle after 3 grant cycles.
    foreach (rr_order[k]) begin
      b = 5'b00001 << rr_order[k];
      add("rr_g0",    5'b11111,       5'b00000, b,     1'b1, 3'(rr_order[k]), 1'b0, 1'b0);
      add("rr_d1",    5'b11111,       b,        b,     1'b1, 3'(rr_order[k]), 1'b1, 1'b1);
      add("rr_d2",    5'b11111,       ~b,       b,     1'b1, 3'(rr_order[k]), 1'b1, 1'b0);
      add("rr_drop",  5'b11111 & ~b,  5'b11111, 5'b0,  1'b0, 3'(rr_order[k]), 1'b0, 1'b0);
      add("rr_guard", 5'b11111,       5'b11111, 5'b0,  1'b0, 3'(rr_order[k]), 1'b0, 1'b0);
    end
    // Wrap and skip: steer ptr to 4 via port 3, then req=00101.
    add("ws_p3",     5'b01000, 5'b0, 5'b01000, 1'b1, 3'd3, 1'b0, 1'b0);
    add("ws_rel3",   5'b00000, 5'b0, 5'b00000, 1'b0, 3'd3, 1'b0, 1'b0);
    add("ws_guard",  5'b00101, 5'b0, 5'b00000, 1'b0, 3'd3, 1'b0, 1'b0);
    add("ws_wrap",   5'b00101, 5'b0, 5'b00001, 1'b1, 3'd0, 1'b0, 1'b0);
    add("ws_rel0",   5'b00100, 5'b0, 5'b00000, 1'b0, 3'd0, 1'b0, 1'b0);
    add("ws_guard2", 5'b00101, 5'b0, 5'b00000, 1'b0, 3'd0, 1'b0, 1'b0);
    add("ws_skip",   5'b00101, 5'b0, 5'b00100, 1'b1, 3'd2, 1'b0, 1'b0);
    add("ws_rel2",   5'b00000, 5'b0, 5'b00000, 1'b0, 3'd2, 1'b0, 1'b0);
    add("ws_guard3", 5'b00000, 5'b0, 5'b00000, 1'b0, 3'd2, 1'b0, 1'b0);
    // Hold: port 1 keeps the grant for 10 cycles while port 3 also requests.
    add("hold_g",    5'b00010, 5'b0, 5'b00010, 1'b1, 3'd1, 1'b0, 1'b0);
    add("hold_1",    5'b00010, 5'b0, 5'b00010, 1'b1, 3'd1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)
      add("hold_n",  5'b01010, 5'b0, 5'b00010, 1'b1, 3'd1, 1'b1, 1'b0);
    add("hold_rel",  5'b01000, 5'b0, 5'b00000, 1'b0, 3'd1, 1'b0, 1'b0);
    add("hold_grd",  5'b01000, 5'b0, 5'b00000, 1'b0, 3'd1, 1'b0, 1'b0);
    add("hold_p3",   5'b01000, 5'b0, 5'b01000, 1'b1, 3'd3, 1'b0, 1'b0);
    add("p3_rel",    5'b00000, 5'b0, 5'b00000, 1'b0, 3'd3, 1'b0, 1'b0);
    add("p3_guard",  5'b00000, 5'b0, 5'b00000, 1'b0, 3'd3, 1'b0, 1'b0);
    // Sole requester re-granted after its pointer wraps past it.
    add("solo_g",    5'b10000, 5'b0, 5'b10000, 1'b1, 3'd4, 1'b0, 1'b0);
    add("solo_rel",  5'b00000, 5'b0, 5'b00000, 1'b0, 3'd4, 1'b0, 1'b0);
    add("solo_grd",  5'b10000, 5'b0, 5'b00000, 1'b0, 3'd4, 1'b0, 1'b0);
    add("solo_re",   5'b10000, 5'b0, 5'b10000, 1'b1, 3'd4, 1'b0, 1'b0);
    add("solo_rel2", 5'b00000, 5'b0, 5'b00000, 1'b0, 3'd4, 1'b0, 1'b0);
    add("solo_grd2", 5'b00000, 5'b0, 5'b00000, 1'b0, 3'd4, 1'b0, 1'b0);
    add("idle_none", 5'b00000, 5'b0, 5'b00000, 1'b0, 3'd4, 1'b0, 1'b0);
    // Data: port 2 owner, din[2] = 1,0,1,1 while other bits toggle.
    add("dat_g",     5'b00100, 5'b11011, 5'b00100, 1'b1, 3'd2, 1'b0, 1'b0);
    add("dat_0",     5'b00100, 5'b00100, 5'b00100, 1'b1, 3'd2, 1'b1, 1'b1);
    add("dat_1",     5'b00100, 5'b11011, 5'b00100, 1'b1, 3'd2, 1'b1, 1'b0);
    add("dat_2",     5'b00100, 5'b01110, 5'b00100, 1'b1, 3'd2, 1'b1, 1'b1);
    add("dat_3",     5'b00100, 5'b10101, 5'b00100, 1'b1, 3'd2, 1'b1, 1'b1);

    core_rst_n = 1'b0;
    req = '0;
    din = '0;
    repeat (2) @(posedge core_clock);
    #1;
    chk("rst.gnt",      32'(gnt),      32'(0));
    chk("rst.busy",     32'(busy),     32'(0));
    chk("rst.owner_id", 32'(owner_id), 32'(0));
    chk("rst.dout_vld", 32'(dout_vld), 32'(0));
    chk("rst.dout",     32'(dout),     32'(0));
    chk("rst.timeout",  32'(timeout),  32'(0));
    core_rst_n = 1'b1;

`ifndef ARB_TIMEOUT_EN
    for (int i = 0; i < tbl.size(); i++) begin
      req = tbl[i].req;
      din = tbl[i].din;
      exp_q.push_back(tbl[i]);
      tick();
      e = exp_q.pop_front();
      check_vec(i, e);
    end
`else
    // Port 1 held high: 8 grant cycles, forced release with a timeout pulse, then re-grant.
    req = 5'b00010;
    for (int c = 1; c <= 8; c++) begin
      tick();
      chk($sformatf("to_hold%0d.gnt", c), 32'(gnt),     32'(5'b00010));
      chk($sformatf("to_hold%0d.to", c),  32'(timeout), 32'(0));
    end
    tick();
    chk("to_rel.gnt",    32'(gnt),     32'(0));
    chk("to_rel.to",     32'(timeout), 32'(1));
    tick();
    chk("to_idle.gnt",   32'(gnt),     32'(0));
    chk("to_idle.to",    32'(timeout), 32'(0));
    tick();
    chk("to_regnt.gnt",  32'(gnt),     32'(5'b00010));
    chk("to_regnt.to",   32'(timeout), 32'(0));
    req = 5'b00000;
    tick();
    chk("to_drop.gnt",   32'(gnt),     32'(0));
    tick();
    req = 5'b00100;
    tick();
    chk("to_p2.gnt",     32'(gnt),     32'(5'b00100));
    tick();
`endif

    // Asynchronous reset in the middle of port 2's grant.
    #2;
    core_rst_n = 1'b0;
    #1;
    chk("arst.gnt",      32'(gnt),      32'(0));
    chk("arst.busy",     32'(busy),     32'(0));
    chk("arst.dout_vld", 32'(dout_vld), 32'(0));
    chk("arst.dout",     32'(dout),     32'(0));
    tick();
    core_rst_n = 1'b1;
    req = 5'b00001;
    din = '0;
    tick();
    chk("arst_re.gnt",      32'(gnt),      32'(5'b00001));
    chk("arst_re.owner_id", 32'(owner_id), 32'(0));
    chk("arst_re.busy",     32'(busy),     32'(1));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
